// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port 64x8 memory among N_REQ requesters.
// Optional MEM_ARB_LOCK_EN adds a lock input that keeps the memory with the current owner.
module mem_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                      CLK,
    input  logic                      clr,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          rw,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          lock,
`endif
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [2:0]                state_dbg
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE, S_LOCKED} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;
`endif

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id;
    logic [ID_W-1:0]     id_next;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     sel_id;
    logic                win_found;
    logic                lat_rw;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [N_REQ-1:0]    id_onehot;
    logic                take;
    logic                adv_ptr;

    // Scan from ptr upward with wrap; first requester found wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        id_onehot     = '0;
        id_onehot[id] = 1'b1;
        id_next       = (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        adv_ptr   = 1'b0;
        case (state)
            S_IDLE:    if (win_found) state_nxt = S_ACCESS;
            S_ACCESS:  state_nxt = lat_rw ? S_CAPTURE : S_DONE;
            S_CAPTURE: state_nxt = S_DONE;
`ifdef MEM_ARB_LOCK_EN
            S_DONE: begin
                if (lock[id]) begin
                    state_nxt = S_LOCKED;
                end else begin
                    state_nxt = S_IDLE;
                    adv_ptr   = 1'b1;
                end
            end
            // Only the lock owner may start a new access; releasing the lock
            // hands the round-robin pointer on as a normal completion would.
            S_LOCKED: begin
                if (!lock[id]) begin
                    state_nxt = S_IDLE;
                    adv_ptr   = 1'b1;
                end else if (req[id]) begin
                    state_nxt = S_ACCESS;
                end
            end
`else
            S_DONE: begin
                state_nxt = S_IDLE;
                adv_ptr   = 1'b1;
            end
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

`ifdef MEM_ARB_LOCK_EN
    assign sel_id = (state == S_LOCKED) ? id : win_id;
`else
    assign sel_id = win_id;
`endif
    assign take = (state_nxt == S_ACCESS) && (state != S_ACCESS);

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id        <= '0;
            lat_rw    <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            // Operands are copied here so requester changes after the grant are harmless.
            if (take) begin
                id        <= sel_id;
                lat_rw    <= rw[sel_id];
                lat_addr  <= addr[int'(sel_id)*ADDR_W +: ADDR_W];
                lat_wdata <= wdata[int'(sel_id)*DATA_W +: DATA_W];
            end
            if (state == S_CAPTURE) rdata <= mem_rdata;
            if (adv_ptr)            ptr   <= id_next;
        end
    end

    // Memory and handshake outputs decode from state and the latched copy only.
    assign mem_en    = (state == S_ACCESS);
    assign mem_rw    = lat_rw;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign ack       = (state == S_DONE) ? id_onehot : '0;
    assign gnt       = (state == S_ACCESS || state == S_CAPTURE || state == S_DONE) ? id_onehot : '0;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed testbench for mem_rr_arbiter with a behavioural 64x8 single-port memory.
// Lock scenario is exercised only when MEM_ARB_LOCK_EN is defined.
module tb_mem_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic                    CLK;
    logic                    clr;
    logic [N_REQ-1:0]        req_v;
    logic [N_REQ-1:0]        rw_v;
    logic [N_REQ*ADDR_W-1:0] addr_v;
    logic [N_REQ*DATA_W-1:0] wdata_v;
    logic [N_REQ-1:0]        lock_v;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;
    logic                    mem_en;
    logic                    mem_rw;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic [2:0]              state_dbg;

    logic [DATA_W-1:0]       mem [64];

    int n_vec;
    int n_err;

    mem_rr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .clr       (clr),
        .req       (req_v),
        .rw        (rw_v),
        .addr      (addr_v),
        .wdata     (wdata_v),
`ifdef MEM_ARB_LOCK_EN
        .lock      (lock_v),
`endif
        .ack       (ack),
        .gnt       (gnt),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single-port memory: read data appears the cycle after the read access.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_rw) mem_rdata <= mem[mem_addr];
            else        mem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        clr = 1'b0;
        repeat (2) @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_ack(output logic [N_REQ-1:0] a, output int cyc);
        a   = '0;
        cyc = 0;
        while (a == '0 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            a = ack;
        end
    endtask

    // Single requester access from IDLE with per-cycle checks of the memory side.
    task automatic do_access(input int i, input logic is_rd, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int exp_lat,
                             input logic [DATA_W-1:0] exp_rd, input string tag);
        int   cyc;
        int   en_cnt;
        logic seen;
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        req_v[i] = 1'b1;
        rw_v[i]  = is_rd;
        addr_v[i*ADDR_W +: ADDR_W]  = a;
        wdata_v[i*DATA_W +: DATA_W] = d;
        cyc = 0; en_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (busy) chk({tag, "_gnt"}, gnt, oh);
            if (mem_en) begin
                en_cnt++;
                chk({tag, "_maddr"}, mem_addr, a);
                chk({tag, "_mrw"}, mem_rw, is_rd);
                if (!is_rd) chk({tag, "_mwdata"}, mem_wdata, d);
            end
            if (ack != '0) begin
                seen = 1'b1;
                chk({tag, "_ack"}, ack, oh);
                if (is_rd) chk({tag, "_rdata"}, rdata, exp_rd);
            end
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_en_cnt"}, en_cnt, 1);
        req_v[i] = 1'b0;
        @(negedge CLK);
        chk({tag, "_ack_off"}, ack, 0);
        chk({tag, "_idle"}, {gnt, busy, mem_en}, 0);
    endtask

    initial begin
        logic [N_REQ-1:0] a;
        logic [N_REQ-1:0] order [5];
        int cyc, last, k, tot;

        n_vec = 0; n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h80 | 8'(i);
        mem_rdata = '0;
        req_v = '0; rw_v = '0; addr_v = '0; wdata_v = '0; lock_v = '0;
        clr = 1'b1;
        @(negedge CLK);
        do_reset();

        // Reset values
        chk("rst_ack", ack, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_rw", mem_rw, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_state", state_dbg, 0);

        // Single write, then read-back from another requester
        do_access(0, 1'b0, 6'h05, 8'hA5, 2, 8'h00, "t1_wr");
        do_access(2, 1'b1, 6'h05, 8'h00, 3, 8'hA5, "t2_rd");

        // Contention: all four held, round-robin order from ptr=0
        do_reset();
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        for (int i = 0; i < N_REQ; i++) begin
            rw_v[i] = 1'b0;
            addr_v[i*ADDR_W +: ADDR_W]  = 6'(16 + i);
            wdata_v[i*DATA_W +: DATA_W] = 8'(8'hC0 + i);
        end
        req_v = '1;
        k = 0; tot = 0; last = 0;
        while (k < 5 && tot < 60) begin
            @(negedge CLK);
            tot++;
            if (ack != '0) begin
                chk("rr_ack", ack, order[k]);
                if (k > 0) chk("rr_gap", tot - last, 3);
                last = tot;
                k++;
                @(negedge CLK);
                tot++;
                chk("rr_pulse", ack, 0);
            end
        end
        chk("rr_count", k, 5);
        req_v = '0;
        repeat (3) @(negedge CLK);

        // Wrap: top and bottom addresses stay distinct
        do_reset();
        do_access(1, 1'b0, 6'h3F, 8'h3C, 2, 8'h00, "t4_wr");
        do_access(1, 1'b1, 6'h3F, 8'h00, 3, 8'h3C, "t4_rd_top");
        do_access(2, 1'b0, 6'h20, 8'h11, 2, 8'h00, "t4_wr2");
        chk("t4_rdata_hold", rdata, 8'h3C);
        do_access(3, 1'b1, 6'h00, 8'h00, 3, 8'h80, "t4_rd_bot");

        // Reset in CAPTURE; pointer is advanced to 3 beforehand
        do_access(2, 1'b0, 6'h21, 8'h77, 2, 8'h00, "t5_wr");
        req_v[1] = 1'b1; rw_v[1] = 1'b1; addr_v[1*ADDR_W +: ADDR_W] = 6'h3F;
        repeat (2) @(negedge CLK);
        chk("t5_in_capture", state_dbg, 2);
        #1 clr = 1'b0;
        #1;
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_gnt", gnt, 0);
        req_v = '0;
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        rw_v = '0;
        addr_v[1*ADDR_W +: ADDR_W] = 6'h30;
        addr_v[3*ADDR_W +: ADDR_W] = 6'h31;
        req_v = 4'b1010;
        wait_ack(a, cyc);
        chk("t5_first_ack", a, 4'b0010);
        chk("t5_first_lat", cyc, 2);
        req_v[1] = 1'b0;
        wait_ack(a, cyc);
        chk("t5_second_ack", a, 4'b1000);
        req_v = '0;
        repeat (3) @(negedge CLK);
        chk("t5_mem_30", mem[6'h30], 8'h00);

`ifdef MEM_ARB_LOCK_EN
        // Lock: requester 1 keeps the memory for three grants, then 0 follows
        do_reset();
        do_access(0, 1'b0, 6'h08, 8'h01, 2, 8'h00, "t6_pre");
        rw_v = '0;
        addr_v[0*ADDR_W +: ADDR_W] = 6'h09;
        addr_v[1*ADDR_W +: ADDR_W] = 6'h0A;
        lock_v = 4'b0010;
        req_v  = 4'b0011;
        for (int g = 0; g < 3; g++) begin
            wait_ack(a, cyc);
            chk("t6_lock_ack", a, 4'b0010);
        end
        lock_v = '0;
        req_v[1] = 1'b0;
        wait_ack(a, cyc);
        chk("t6_after_unlock", a, 4'b0001);
        req_v = '0;
        repeat (3) @(negedge CLK);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
